uart_tx_fifo: RTL

Byte buffer between the host write side and uart_tx. It accepts bytes at full clk rate and presents them one at a time to uart_tx on data_in. It drives the tx_start strobe for each byte and waits for tx_done before releasing the next byte. tx_start is stretched so that uart_tx, which runs on the slower baud_tick clock, captures it.

---
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding uart_tx. Pops one byte at a time, stretches
// tx_start over several clk cycles and waits for a tx_done rising edge before
// releasing the next byte.
module uart_tx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned START_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              ovf_clr,
  input  logic              tx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [SC_W-1:0]   start_cnt;
  logic              tx_done_q;

  logic              push;
  logic              pop;
  logic              drop;
  logic              done_rise;
  logic [CNT_W-1:0]  count_nxt;

  // Per-cycle push/pop decisions and next occupancy.
  always_comb begin
    push      = wr_en & ~full;
    drop      = wr_en & full;
    pop       = (state == IDLE) & ~empty;
    done_rise = tx_done & ~tx_done_q;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage array; a push never targets the slot being read since push implies not full.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags, overflow and tx_done edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      count     <= count_nxt;
      full      <= (count_nxt == CNT_W'(DEPTH));
      empty     <= (count_nxt == '0);
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      // A dropped write outranks a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit handshake FSM: pop, hold tx_start, then wait for completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      start_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data   <= mem[rd_ptr];
            start_cnt <= '0;
            tx_start  <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (start_cnt == SC_W'(START_CYCLES - 1)) begin
            tx_start <= 1'b0;
            state    <= WAIT;
          end else begin
            start_cnt <= start_cnt + SC_W'(1);
          end
        end
        WAIT: begin
          if (done_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
